aes_iter_cipher: RTL and testbench

Iterative AES-128 encryption engine. It runs one round per clock, expands round keys on the fly, and supports ECB/CBC/CTR chaining with valid/ready streaming handshakes. Successor to the fully unrolled cipher: same round function (existing combinational SubBytes/ShiftRows/MixColumns/AddRoundKey and key-schedule step from the crypto library), about one tenth of the area, plus per-round debug tap capture and a block counter. Sits between the host data source and the display/transmit path.

---
 rtl/aes_iter_cipher.sv | 213 +++++++++++++++++++++
 tb/tb_aes_iter_cipher.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128 encryption engine: one round per clock, on-the-fly key expansion,
// ECB/CBC/CTR chaining, valid/ready streaming, debug tap capture and block counter.
module aes_iter_cipher #(
  parameter int CTR_W  = 32,
  parameter int CNT_W  = 16,
  parameter int TAP_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  input  logic [3:0]       tap_sel,
  output logic [127:0]     tap_data,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] M_CBC   = 2'd1;
  localparam logic [1:0] M_CTR   = 2'd2;

  // Shifting past bit 127 yields zero, so CTR_W = 128 gives an all-ones mask.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i of the state is row i%4, column i/4; SubBytes and ShiftRows are fused.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk_in,
                                             input logic last);
    logic [127:0] t;
    logic [127:0] m;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = sbox(s[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8]);
    for (int c = 0; c < 4; c++)
      m[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
    return (last ? t : m) ^ rk_in;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   fsm;
  logic [1:0]   mode_reg;
  logic [127:0] key_reg, chain, ctr, din_reg, state, rk;
  logic [3:0]   rnd;
  logic [127:0] pre, rk_nxt, state_nxt, ct_final, ctr_inc, tap_val;
  logic         accept, last_rnd, tap_hit;

  assign in_ready  = ((fsm == S_IDLE) && !cfg_load) || ((fsm == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (fsm == S_ROUND) || (fsm == S_DONE);
  assign last_rnd  = (rnd == 4'd10);
  assign rk_nxt    = key_step(rk, rcon(rnd));
  assign state_nxt = aes_round(state, rk_nxt, last_rnd);
  assign ct_final  = (mode_reg == M_CTR) ? (state_nxt ^ din_reg) : state_nxt;
  assign ctr_inc   = (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);

  always_comb begin
    case (mode_reg)
      M_CBC:   pre = in_data ^ chain;
      M_CTR:   pre = ctr;
      default: pre = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      blk_count <= '0;
      key_reg   <= '0;
      mode_reg  <= 2'd0;
      chain     <= '0;
      ctr       <= '0;
      din_reg   <= '0;
      state     <= '0;
      rk        <= '0;
      rnd       <= '0;
    end else begin
      case (fsm)
        S_IDLE: if (cfg_load) begin
          key_reg   <= key;
          mode_reg  <= cfg_mode;
          blk_count <= '0;
          if (cfg_mode == M_CBC) chain <= iv;
          if (cfg_mode == M_CTR) ctr <= iv;
        end
        S_ROUND: begin
          rk    <= rk_nxt;
          state <= state_nxt;
          rnd   <= rnd + 4'd1;
          if (last_rnd) begin
            fsm       <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= ct_final;
            if (mode_reg == M_CBC) chain <= ct_final;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          blk_count <= blk_count + 1'b1;
          fsm       <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
      // A block accepted in DONE overrides the return to IDLE.
      if (accept) begin
        state <= pre ^ key_reg;
        rk    <= key_reg;
        rnd   <= 4'd1;
        fsm   <= S_ROUND;
        if (mode_reg == M_CTR) begin
          din_reg <= in_data;
          ctr     <= ctr_inc;
        end
      end
    end
  end

  always_comb begin
    tap_hit = 1'b0;
    tap_val = state_nxt;
    if (accept) begin
      case (tap_sel)
        4'd0:  begin tap_hit = 1'b1; tap_val = pre ^ key_reg; end
        4'd11: begin tap_hit = 1'b1; tap_val = in_data;       end
        4'd12: begin tap_hit = 1'b1; tap_val = key_reg;       end
        default: tap_hit = 1'b0;
      endcase
    end else if (fsm == S_ROUND) begin
      if (tap_sel == rnd) begin
        tap_hit = 1'b1;
        tap_val = state_nxt;
      end else if ((tap_sel == 4'd13) && last_rnd) begin
        tap_hit = 1'b1;
        tap_val = rk_nxt;
      end
    end
  end

  if (TAP_EN != 0) begin : g_tap
    logic [127:0] tap_q;
    always_ff @(posedge clk) begin
      if (rst)          tap_q <= '0;
      else if (tap_hit) tap_q <= tap_val;
    end
    assign tap_data = tap_q;
  end else begin : g_no_tap
    assign tap_data = '0;
  end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Randomized self-checking bench for aes_iter_cipher against a byte-level AES model
// built from GF(2^8) arithmetic, plus the reference known-answer vectors.
module tb_aes_iter_cipher;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_load = 1'b0;
  logic [1:0]   cfg_mode = 2'd0;
  logic [127:0] key = '0, iv = '0, in_data = '0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   tap_sel = 4'd0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data, tap_data;
  logic [15:0]  blk_count;

  aes_iter_cipher #(.CTR_W(32), .CNT_W(16), .TAP_EN(1)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .tap_sel(tap_sel), .tap_data(tap_data), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_sbox [256];
  logic [127:0] m_st [11];
  logic [127:0] m_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_aes(input logic [127:0] k, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]], m_sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ m_rk[0][127-8*i -: 8];
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    m_st[0] = v;
    for (int r = 1; r < 11; r++) begin
      for (int i = 0; i < 16; i++) u[i] = m_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = u[row + 4*((c + row) % 4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ m_rk[r][127-8*i -: 8];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      m_st[r] = v;
    end
  endtask

  // ---------------- bench-side view of the engine ----------------
  logic [127:0] b_key = '0, b_chain = '0, b_ctr = '0, b_last = '0, tap_exp = '0;
  logic [1:0]   b_mode = 2'd0;
  logic [15:0]  b_cnt = '0;
  bit           pending = 0, stalled = 0;
  int           last_acc = 0;

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    pending = 0;
    stalled = 0;
    b_cnt++;
    check("drain_valid", 128'(out_valid), 128'd0);
    check("drain_count", 128'(blk_count), 128'(b_cnt));
  endtask

  task automatic load(input logic [1:0] mode, input logic [127:0] k, input logic [127:0] v);
    if (pending) drain();
    cfg_mode = mode; key = k; iv = v; cfg_load = 1'b1;
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("cfg_blocks_ready", 128'(in_ready), 128'd0);
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    b_key = k; b_mode = mode; b_cnt = '0;
    if (mode == 2'd1) b_chain = v;
    if (mode == 2'd2) b_ctr = v;
    check("cfg_no_accept", 128'(busy), 128'd0);
    check("cfg_count_clr", 128'(blk_count), 128'd0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("stall_valid", 128'(out_valid), 128'd1);
      check("stall_data", out_data, b_last);
      check("stall_ready", 128'(in_ready), 128'd0);
      check("stall_count", 128'(blk_count), 128'(b_cnt));
    end
    stalled = 1;
  endtask

  task automatic do_block(input logic [127:0] pt, input logic [3:0] sel, input bit poke);
    logic [127:0] pre, ct;
    int lat;
    case (b_mode)
      2'd1:    pre = pt ^ b_chain;
      2'd2:    pre = b_ctr;
      default: pre = pt;
    endcase
    model_aes(b_key, pre);
    ct = (b_mode == 2'd2) ? (m_st[10] ^ pt) : m_st[10];
    if (sel <= 4'd10)       tap_exp = m_st[sel];
    else if (sel == 4'd11)  tap_exp = pt;
    else if (sel == 4'd12)  tap_exp = b_key;
    else if (sel == 4'd13)  tap_exp = m_rk[10];
    in_data = pt; in_valid = 1'b1; tap_sel = sel; out_ready = pending;
    #1;
    check("accept_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    if (pending) begin
      b_cnt++;
      if (!stalled) check("period", 128'(cyc - last_acc), 128'd11);
    end
    last_acc = cyc;
    if (b_mode == 2'd1) b_chain = ct;
    if (b_mode == 2'd2) b_ctr = {b_ctr[127:32], b_ctr[31:0] + 32'd1};
    lat = 0;
    while (!out_valid && lat < 30) begin
      cfg_load = poke && (lat == 2);
      if (cfg_load) begin
        key = ~b_key; cfg_mode = 2'd2; iv = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      cfg_load = 1'b0;
      lat++;
    end
    check("latency", 128'(lat), 128'd10);
    check("out_data", out_data, ct);
    check("tap_data", tap_data, tap_exp);
    check("busy_done", 128'(busy), 128'd1);
    check("count_run", 128'(blk_count), 128'(b_cnt));
    b_last = ct;
    pending = 1;
    stalled = 0;
  endtask

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] iv_w;
    build_sbox();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_tap", tap_data, 128'd0);
    check("rst_count", 128'(blk_count), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);

    load(2'd0, KEY1, '0);
    do_block(PT1, 4'd11, 0);
    check("kat_ecb1", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain();
    check("kat_ecb1_count", 128'(blk_count), 128'd1);

    load(2'd0, KEY2, '0);
    do_block(PT2, 4'd1, 0);
    check("kat_tap_r1", tap_data, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("kat_ecb2", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    do_block(PT2, 4'd13, 0);
    check("kat_tap_rk10", tap_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    load(2'd1, KEY2, 128'h000102030405060708090a0b0c0d0e0f);
    do_block(P1, 4'd2, 0);
    check("kat_cbc1", out_data, 128'h7649abac8119b246cee98e9b12e9197d);
    do_block(P2, 4'd12, 0);
    check("kat_cbc2", out_data, 128'h5086cb9b507219ee95db113a917678b2);

    load(2'd2, KEY2, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    do_block(P1, 4'd0, 0);
    check("kat_ctr1", out_data, 128'h874d6191b620e3261bef6864990db6ce);
    do_block(P2, 4'd5, 0);
    check("kat_ctr2", out_data, 128'h9806f66b7970fdff8617187bb9fffdff);

    iv_w = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
    load(2'd2, KEY2, iv_w);
    do_block({$urandom, $urandom, $urandom, $urandom}, 4'd3, 0);
    do_block({$urandom, $urandom, $urandom, $urandom}, 4'd0, 0);
    check("ctr_wrap", tap_data ^ KEY2, {iv_w[127:32], 32'h0});

    load(2'd0, KEY2, '0);
    do_block(PT2, 4'd7, 1);
    stall(5);
    do_block(PT2, 4'd14, 0);
    check("cfg_in_round_ignored", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    drain();

    in_data = PT1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd1);
    check("mid_rst_tap", tap_data, 128'd0);
    check("mid_rst_count", 128'(blk_count), 128'd0);
    b_key = '0; b_mode = 2'd0; b_chain = '0; b_ctr = '0; b_cnt = '0; tap_exp = '0; pending = 0;
    load(2'd0, KEY1, '0);
    do_block(PT1, 4'd9, 0);
    check("post_rst_ecb", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    for (int b = 0; b < 24; b++) begin
      if (b % 6 == 0)
        load(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom});
      if (pending && $urandom_range(0, 2) == 0) stall($urandom_range(1, 3));
      if (pending && $urandom_range(0, 3) == 0) drain();
      do_block({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)), 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
